// File: rtl/render_pass_scheduler.sv
// Render pass scheduler: frame-rate tick generator plus a fixed-order arbiter that hands the
// single vga_adapter write port to each drawer client in turn, once per frame.
module render_pass_scheduler #(
    parameter int unsigned NUM_CLIENTS  = 3,
    parameter int unsigned XW           = 8,
    parameter int unsigned YW           = 7,
    parameter int unsigned FRAME_CYCLES = 833333
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic [NUM_CLIENTS-1:0]    req_i,
    input  logic [NUM_CLIENTS-1:0]    done_i,
    input  logic [NUM_CLIENTS*XW-1:0] cx_i,
    input  logic [NUM_CLIENTS*YW-1:0] cy_i,
    input  logic [NUM_CLIENTS*3-1:0]  ccol_i,
    output logic [NUM_CLIENTS-1:0]    grant_o,
    output logic [XW-1:0]             vga_x_o,
    output logic [YW-1:0]             vga_y_o,
    output logic [2:0]                vga_colour_o,
    output logic                      vga_plot_o,
    output logic                      frame_tick_o,
    output logic                      pass_active_o,
    output logic                      frame_done_o,
    output logic                      overrun_o
);

    localparam int unsigned CntW = $clog2(FRAME_CYCLES);
    localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPass,
        StDone
    } state_e;

    state_e          state_q;
    logic [IdxW-1:0] idx_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XW-1:0]   vga_x_q;
    logic [YW-1:0]   vga_y_q;
    logic [2:0]      vga_colour_q;
    logic            vga_plot_q;

    logic            frame_tick;
    logic            sel_req, sel_done;
    logic [XW-1:0]   sel_x;
    logic [YW-1:0]   sel_y;
    logic [2:0]      sel_col;
    logic            accept;

    // Frame counter next state: wraps at the frame boundary, freezes while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (enable_i) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Frame counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_tick = enable_i && (cnt_q == CntLast);

    // Select the currently owned client's handshake and pixel, and decode grant from state only.
    always_comb begin
        sel_req  = 1'b0;
        sel_done = 1'b0;
        sel_x    = '0;
        sel_y    = '0;
        sel_col  = '0;
        grant_o  = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (idx_q == IdxW'(k)) begin
                sel_req  = req_i[k];
                sel_done = done_i[k];
                sel_x    = cx_i[k*XW +: XW];
                sel_y    = cy_i[k*YW +: YW];
                sel_col  = ccol_i[k*3 +: 3];
            end
            grant_o[k] = (state_q == StPass) && (idx_q == IdxW'(k));
        end
    end

    assign accept = (state_q == StPass) && sel_req;

    // Pass sequencer and registered pixel port; coordinates hold when nothing is accepted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            vga_plot_q <= accept;
            if (accept) begin
                vga_x_q      <= sel_x;
                vga_y_q      <= sel_y;
                vga_colour_q <= sel_col;
            end
            unique case (state_q)
                StIdle: begin
                    if (frame_tick) begin
                        state_q <= StPass;
                        idx_q   <= '0;
                    end
                end
                StPass: begin
                    if (sel_done) begin
                        if (idx_q == IdxLast) begin
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + IdxW'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign vga_x_o       = vga_x_q;
    assign vga_y_o       = vga_y_q;
    assign vga_colour_o  = vga_colour_q;
    assign vga_plot_o    = vga_plot_q;
    assign frame_tick_o  = frame_tick;
    assign pass_active_o = (state_q != StIdle);
    assign frame_done_o  = (state_q == StDone);
    // A tick while busy is reported and dropped rather than queued.
    assign overrun_o     = frame_tick && (state_q != StIdle);

endmodule

// File: tb/tb_render_pass_scheduler.sv
// Scoreboard bench for render_pass_scheduler with a 10-cycle frame.
module tb_render_pass_scheduler;

    localparam int NC = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int FC = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [NC-1:0]    req, done, grant;
    logic [NC*XW-1:0] cx;
    logic [NC*YW-1:0] cy;
    logic [NC*3-1:0]  ccol;
    logic [XW-1:0]    vga_x;
    logic [YW-1:0]    vga_y;
    logic [2:0]       vga_colour;
    logic             vga_plot, frame_tick, pass_active, frame_done, overrun;

    always #5 clk = ~clk;

    render_pass_scheduler #(
        .NUM_CLIENTS (NC),
        .XW          (XW),
        .YW          (YW),
        .FRAME_CYCLES(FC)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .req_i        (req),
        .done_i       (done),
        .cx_i         (cx),
        .cy_i         (cy),
        .ccol_i       (ccol),
        .grant_o      (grant),
        .vga_x_o      (vga_x),
        .vga_y_o      (vga_y),
        .vga_colour_o (vga_colour),
        .vga_plot_o   (vga_plot),
        .frame_tick_o (frame_tick),
        .pass_active_o(pass_active),
        .frame_done_o (frame_done),
        .overrun_o    (overrun)
    );

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_tick = 0;
    int   n_ovr = 0;
    int   snap_tick, snap_ovr, ph, exp_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input logic [NC-1:0] m);
        int n = 0;
        while (grant !== m && n < 40) begin
            step();
            n++;
        end
        check_eq(tag, 32'(grant), 32'(m));
    endtask

    // Present a pixel from client k; the expected plot lands one cycle later.
    task automatic drive_pix(input int k, input int x, input int y, input int c);
        req[k]         = 1'b1;
        cx[k*XW +: XW] = XW'(x);
        cy[k*YW +: YW] = YW'(y);
        ccol[k*3 +: 3] = 3'(c);
        exp_q.push_back('{x: x, y: y, c: c, cyc: cyc + 1});
    endtask

    task automatic chk_zero(input string tag);
        check_eq({tag, "_grant"}, 32'(grant), 0);
        check_eq({tag, "_plot"}, 32'(vga_plot), 0);
        check_eq({tag, "_x"}, 32'(vga_x), 0);
        check_eq({tag, "_y"}, 32'(vga_y), 0);
        check_eq({tag, "_col"}, 32'(vga_colour), 0);
        check_eq({tag, "_tick"}, 32'(frame_tick), 0);
        check_eq({tag, "_active"}, 32'(pass_active), 0);
        check_eq({tag, "_fdone"}, 32'(frame_done), 0);
        check_eq({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every plot must match the head of the scoreboard, on the expected cycle.
    always @(negedge clk) begin
        if (frame_tick === 1'b1) n_tick++;
        if (overrun === 1'b1) n_ovr++;
        if (vga_plot === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("plot_unexpected", 32'(vga_plot), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("plot_x", 32'(vga_x), 32'(mon_e.x));
                check_eq("plot_y", 32'(vga_y), 32'(mon_e.y));
                check_eq("plot_col", 32'(vga_colour), 32'(mon_e.c));
                check_eq("plot_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        req    = '0;
        done   = '0;
        cx     = '0;
        cy     = '0;
        ccol   = '0;
        step();
        step();
        step();
        chk_zero("rst");

        // Idle frames: every client finishes immediately.
        done  = 3'b111;
        reset = 1'b0;
        for (int i = 0; i < 35; i++) begin
            ph = i % 10;
            exp_g = 0;
            if (i >= 10 && ph == 0) exp_g = 1;
            if (i >= 10 && ph == 1) exp_g = 2;
            if (i >= 10 && ph == 2) exp_g = 4;
            check_eq("t1_tick", 32'(frame_tick), 32'(ph == 9));
            check_eq("t1_grant", 32'(grant), 32'(exp_g));
            check_eq("t1_fdone", 32'(frame_done), 32'(i >= 10 && ph == 3));
            check_eq("t1_active", 32'(pass_active), 32'(i >= 10 && ph <= 3));
            check_eq("t1_overrun", 32'(overrun), 0);
            step();
        end

        // Pixel stream through clients 0 and 2, client 1 empty.
        done = '0;
        wait_grant("t2_g0", 3'b001);
        drive_pix(0, 5, 100, 6);
        step();
        drive_pix(0, 6, 100, 6);
        step();
        drive_pix(0, 7, 100, 6);
        done[0] = 1'b1;
        step();
        check_eq("t2_g1", 32'(grant), 2);
        req = '0;
        done = 3'b010;
        step();
        check_eq("t2_g2", 32'(grant), 4);
        check_eq("t2_hold_x", 32'(vga_x), 7);
        done = 3'b100;
        drive_pix(2, 15, 93, 0);
        step();
        req  = '0;
        done = '0;
        check_eq("t2_fdone", 32'(frame_done), 1);
        check_eq("t2_grant_off", 32'(grant), 0);
        check_eq("t2_active", 32'(pass_active), 1);
        step();
        check_eq("t2_idle", 32'(pass_active), 0);
        check_eq("t2_fdone_pulse", 32'(frame_done), 0);

        // Non-granted client 2 requests early; its pixel must wait for its turn.
        wait_grant("t4_g0", 3'b001);
        req[2]      = 1'b1;
        cx[2*XW +: XW] = 8'd50;
        cy[2*YW +: YW] = 7'd10;
        ccol[2*3 +: 3] = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t4_hold_g0", 32'(grant), 1);
        end
        done = 3'b001;
        step();
        check_eq("t4_g1", 32'(grant), 2);
        done = 3'b010;
        step();
        check_eq("t4_g2", 32'(grant), 4);
        done = 3'b100;
        drive_pix(2, 50, 10, 3);
        step();
        req  = '0;
        done = '0;
        check_eq("t4_fdone", 32'(frame_done), 1);

        // Client 1 stalls across a frame boundary.
        wait_grant("t3_g0", 3'b001);
        snap_ovr  = n_ovr;
        snap_tick = n_tick;
        done = 3'b001;
        step();
        check_eq("t3_g1", 32'(grant), 2);
        done = '0;
        for (int i = 0; i < 12; i++) step();
        check_eq("t3_still_g1", 32'(grant), 2);
        done = 3'b010;
        step();
        check_eq("t3_g2", 32'(grant), 4);
        done = 3'b100;
        step();
        done = '0;
        check_eq("t3_fdone", 32'(frame_done), 1);
        check_eq("t3_overrun_cnt", 32'(n_ovr - snap_ovr), 1);
        check_eq("t3_tick_cnt", 32'(n_tick - snap_tick), 1);
        step();
        check_eq("t3_no_requeue", 32'(pass_active), 0);

        // Disable mid-pass: the pass still completes, then everything stays quiet.
        wait_grant("t5_g0", 3'b001);
        enable    = 1'b0;
        snap_tick = n_tick;
        done = 3'b111;
        step();
        step();
        step();
        check_eq("t5_fdone", 32'(frame_done), 1);
        done = '0;
        for (int i = 0; i < 25; i++) step();
        check_eq("t5_no_tick", 32'(n_tick - snap_tick), 0);
        check_eq("t5_idle", 32'(pass_active), 0);
        enable = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            check_eq("t5_resume_quiet", 32'(frame_tick), 0);
            step();
        end
        check_eq("t5_resume_tick", 32'(frame_tick), 1);

        // Asynchronous reset in the middle of a pass.
        step();
        check_eq("t6_g0", 32'(grant), 1);
        check_eq("t6_active", 32'(pass_active), 1);
        check_eq("t6_x_before", 32'(vga_x), 50);
        #3;
        reset = 1'b1;
        #1;
        chk_zero("t6_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("t6_no_resume", 32'(grant), 0);
        for (int i = 0; i < 9; i++) begin
            check_eq("t6_quiet", 32'(frame_tick), 0);
            step();
        end
        check_eq("t6_tick", 32'(frame_tick), 1);
        step();
        check_eq("t6_new_pass", 32'(grant), 1);
        done = 3'b111;
        for (int i = 0; i < 5; i++) step();
        check_eq("queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
